// File: rtl/exc_vector_loader_pkg.sv
// Shared encodings for the exception vector loader: sequencer states and
// IorD select codes driven onto the memory address mux.
package exc_vector_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAVE_EPC = 3'd1,
    ST_ADDR     = 3'd2,
    ST_WAIT     = 3'd3,
    ST_LOAD_PC  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [2:0] IORD_PC   = 3'b000;
  localparam logic [2:0] IORD_V253 = 3'b001;
  localparam logic [2:0] IORD_V254 = 3'b010;
  localparam logic [2:0] IORD_V255 = 3'b011;
  localparam logic [2:0] IORD_DATA = 3'b100;

  // Vector table entries are single bytes; PC gets them zero-extended.
  function automatic logic [31:0] zext_byte(input logic [7:0] b);
    return {24'b0, b};
  endfunction

endpackage

// File: rtl/exc_vector_loader_priority_enc.sv
// Fixed-priority encoder: opcode > overflow > div0, mapped to the IorD code
// of the matching vector address.
module exc_priority_enc
  import exc_vector_loader_pkg::*;
(
  input  logic       exc_opcode_i,
  input  logic       exc_overflow_i,
  input  logic       exc_div0_i,
  output logic [2:0] code_o,
  output logic       valid_o
);

  always_comb begin
    code_o  = IORD_PC;
    valid_o = exc_opcode_i | exc_overflow_i | exc_div0_i;
    if (exc_opcode_i)        code_o = IORD_V253;
    else if (exc_overflow_i) code_o = IORD_V254;
    else if (exc_div0_i)     code_o = IORD_V255;
  end

endmodule

// File: rtl/exc_vector_loader.sv
// Exception vector loader: saves EPC, reads the cause's vector byte from
// memory and loads it into PC while holding the shared ports via busy.
module exc_vector_loader
  import exc_vector_loader_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int EPC_OFFSET  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  iord_sel,
  output logic        mem_rd,
  output logic [31:0] epc_out,
  output logic        epc_write,
  output logic [31:0] pc_out,
  output logic        pc_write,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_e           state_q;
  logic [2:0]       cause_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       iord_sel_q;
  logic             mem_rd_q;
  logic [31:0]      epc_q;
  logic             epc_we_q;
  logic [31:0]      pc_q;
  logic             pc_we_q;
  logic             busy_q;
  logic             done_q;

  logic [2:0]  req_code;
  logic        req_vld;
  logic [31:0] epc_d;
  logic [31:0] pc_d;
  logic        unused_data_hi;

  exc_priority_enc u_prio (
    .exc_opcode_i   (exc_opcode),
    .exc_overflow_i (exc_overflow),
    .exc_div0_i     (exc_div0),
    .code_o         (req_code),
    .valid_o        (req_vld)
  );

  // PC has already been incremented past the faulting instruction; wraps mod 2^32.
  assign epc_d          = pc_in - 32'(EPC_OFFSET);
  assign pc_d           = zext_byte(mem_data_in[7:0]);
  assign unused_data_hi = ^mem_data_in[31:8];

  // Outputs are registered together with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cause_q    <= IORD_PC;
      cnt_q      <= '0;
      iord_sel_q <= IORD_PC;
      mem_rd_q   <= 1'b0;
      epc_q      <= '0;
      epc_we_q   <= 1'b0;
      pc_q       <= '0;
      pc_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      epc_we_q <= 1'b0;
      pc_we_q  <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_vld) begin
            cause_q  <= req_code;
            epc_q    <= epc_d;
            epc_we_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_SAVE_EPC;
          end
        end
        ST_SAVE_EPC: begin
          iord_sel_q <= cause_q;
          mem_rd_q   <= 1'b1;
          state_q    <= ST_ADDR;
        end
        ST_ADDR: begin
          cnt_q   <= CNT_INIT;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            pc_q     <= pc_d;
            pc_we_q  <= 1'b1;
            mem_rd_q <= 1'b0;
            state_q  <= ST_LOAD_PC;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_LOAD_PC: begin
          iord_sel_q <= IORD_PC;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          iord_sel_q <= IORD_PC;
          mem_rd_q   <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign iord_sel  = iord_sel_q;
  assign mem_rd    = mem_rd_q;
  assign epc_out   = epc_q;
  assign epc_write = epc_we_q;
  assign pc_out    = pc_q;
  assign pc_write  = pc_we_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_exc_vector_loader.sv
// Bench for exc_vector_loader: two builds (MEM_LATENCY 2 and 1) share the
// stimulus; an offset-based timeline model is compared every cycle.
module tb_exc_vector_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exc_opcode = 1'b0, exc_overflow = 1'b0, exc_div0 = 1'b0;
  logic [31:0] pc_in = '0, mem_data_in = '0;

  logic [2:0]  iord_sel [2];
  logic        mem_rd [2], epc_write [2], pc_write [2], busy [2], done [2];
  logic [31:0] epc_out [2], pc_out [2];

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  exc_vector_loader #(.MEM_LATENCY(2), .EPC_OFFSET(4)) dut_l2 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_div0(exc_div0), .pc_in(pc_in), .mem_data_in(mem_data_in),
    .iord_sel(iord_sel[0]), .mem_rd(mem_rd[0]), .epc_out(epc_out[0]),
    .epc_write(epc_write[0]), .pc_out(pc_out[0]), .pc_write(pc_write[0]),
    .busy(busy[0]), .done(done[0]));

  exc_vector_loader #(.MEM_LATENCY(1), .EPC_OFFSET(4)) dut_l1 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_div0(exc_div0), .pc_in(pc_in), .mem_data_in(mem_data_in),
    .iord_sel(iord_sel[1]), .mem_rd(mem_rd[1]), .epc_out(epc_out[1]),
    .epc_write(epc_write[1]), .pc_out(pc_out[1]), .pc_write(pc_write[1]),
    .busy(busy[1]), .done(done[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Timeline model: an accepted request starts a sequence; every output is a
  // function of the cycle offset k since acceptance (k=1 is the EPC cycle).
  int          edges = 0;
  bit          m_act [2];
  int          m_start [2];
  logic [2:0]  m_cause [2];
  logic [31:0] m_epc [2], m_pc [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_epc[i] = '0; m_pc[i] = '0; m_cause[i] = '0; m_start[i] = 0;
      end
    end else begin
      edges++;
      for (int i = 0; i < 2; i++) begin
        if (m_act[i] && (edges - m_start[i] == 3 + lat(i)))
          m_pc[i] = {24'b0, mem_data_in[7:0]};
        if (m_act[i] && (edges - m_start[i] == 5 + lat(i))) begin
          m_act[i] = 1'b0;
        end else if (!m_act[i] && (exc_opcode || exc_overflow || exc_div0)) begin
          m_act[i]   = 1'b1;
          m_start[i] = edges - 1;
          m_cause[i] = exc_opcode ? 3'd1 : (exc_overflow ? 3'd2 : 3'd3);
          m_epc[i]   = pc_in - 32'd4;
        end
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      for (int i = 0; i < 2; i++) begin
        int k, L;
        bit a;
        L = lat(i);
        a = m_act[i];
        k = edges - m_start[i];
        chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(a && k >= 1 && k <= 3 + L));
        chk($sformatf("epc_write[%0d]", i), 32'(epc_write[i]), 32'(a && k == 1));
        chk($sformatf("iord_sel[%0d]", i), 32'(iord_sel[i]),
            (a && k >= 2 && k <= 3 + L) ? 32'(m_cause[i]) : 32'd0);
        chk($sformatf("mem_rd[%0d]", i), 32'(mem_rd[i]), 32'(a && k >= 2 && k <= 2 + L));
        chk($sformatf("pc_write[%0d]", i), 32'(pc_write[i]), 32'(a && k == 3 + L));
        chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(a && k == 4 + L));
        chk($sformatf("epc_out[%0d]", i), epc_out[i], m_epc[i]);
        chk($sformatf("pc_out[%0d]", i), pc_out[i], m_pc[i]);
      end
    end
  end

  // pc_write bookkeeping for the latency and single-load checks.
  int pcw_cnt [2];
  int pcw_edge [2];
  initial begin
    pcw_cnt = '{0, 0};
    pcw_edge = '{0, 0};
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (pc_write[i] === 1'b1) begin
        pcw_cnt[i]++;
        pcw_edge[i] = edges;
      end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s iord_sel[%0d]", tag, i), 32'(iord_sel[i]), 32'd0);
      chk($sformatf("%s busy[%0d]", tag, i), 32'(busy[i]), 32'd0);
      chk($sformatf("%s enables[%0d]", tag, i),
          32'({mem_rd[i], epc_write[i], pc_write[i], done[i]}), 32'd0);
      chk($sformatf("%s epc_out[%0d]", tag, i), epc_out[i], 32'd0);
      chk($sformatf("%s pc_out[%0d]", tag, i), pc_out[i], 32'd0);
    end
  endtask

  initial begin
    int x, base0, base1;
    #1 reset = 1'b1;
    #1 chk_all_zero("reset");
    step();
    step();
    reset = 1'b0;
    chk_en = 1'b1;
    step();

    // Overflow: EPC = 0x104 - 4, vector 254, PC <- 0x3C.
    pc_in = 32'h104; mem_data_in = 32'h0000_AB3C;
    base0 = pcw_cnt[0]; base1 = pcw_cnt[1]; x = edges;
    exc_overflow = 1'b1;
    step();
    exc_overflow = 1'b0;
    chk("t1 epc_write", 32'(epc_write[0]), 32'd1);
    chk("t1 epc_out", epc_out[0], 32'h100);
    step();
    chk("t1 iord_sel", 32'(iord_sel[0]), 32'b010);
    repeat (8) step();
    chk("t1 pc_out L2", pc_out[0], 32'h3C);
    chk("t1 pc_out L1", pc_out[1], 32'h3C);
    chk("t1 one load L2", 32'(pcw_cnt[0] - base0), 32'd1);
    chk("t1 latency L2", 32'(pcw_edge[0] - x), 32'd5);
    chk("t6 latency L1", 32'(pcw_edge[1] - x), 32'd4);
    chk("t1 one load L1", 32'(pcw_cnt[1] - base1), 32'd1);

    // Opcode and div0 together: opcode wins, div0 is not queued.
    pc_in = 32'h200; mem_data_in = 32'h0000_0055;
    base0 = pcw_cnt[0];
    exc_opcode = 1'b1; exc_div0 = 1'b1;
    step();
    exc_opcode = 1'b0; exc_div0 = 1'b0;
    step();
    chk("t2 iord_sel", 32'(iord_sel[0]), 32'b001);
    repeat (10) step();
    chk("t2 one load", 32'(pcw_cnt[0] - base0), 32'd1);
    chk("t2 pc_out", pc_out[0], 32'h55);

    // EPC wraps below zero.
    pc_in = 32'h0; mem_data_in = 32'h0000_00F1;
    exc_div0 = 1'b1;
    step();
    exc_div0 = 1'b0;
    chk("t3 epc_out", epc_out[0], 32'hFFFF_FFFC);
    step();
    chk("t3 iord_sel", 32'(iord_sel[0]), 32'b011);
    repeat (8) step();

    // Reset while both builds sit in WAIT aborts the load.
    pc_in = 32'h300; mem_data_in = 32'h0000_0077;
    exc_div0 = 1'b1;
    step();
    exc_div0 = 1'b0;
    step();
    step();
    base0 = pcw_cnt[0]; base1 = pcw_cnt[1];
    #1 reset = 1'b1;
    #1 chk_all_zero("t4 abort");
    step();
    step();
    reset = 1'b0;
    repeat (6) step();
    chk("t4 no load L2", 32'(pcw_cnt[0] - base0), 32'd0);
    chk("t4 no load L1", 32'(pcw_cnt[1] - base1), 32'd0);
    pc_in = 32'h400; mem_data_in = 32'h0000_1299;
    exc_div0 = 1'b1;
    step();
    exc_div0 = 1'b0;
    chk("t4 epc_out", epc_out[0], 32'h3FC);
    repeat (9) step();
    chk("t4 pc_out", pc_out[0], 32'h99);
    chk("t4 one load", 32'(pcw_cnt[0] - base0), 32'd1);

    // Re-request while busy is ignored.
    pc_in = 32'h500; mem_data_in = 32'h0000_0012;
    base0 = pcw_cnt[0]; base1 = pcw_cnt[1];
    exc_opcode = 1'b1;
    step();
    exc_opcode = 1'b0;
    step();
    exc_opcode = 1'b1;
    step();
    step();
    exc_opcode = 1'b0;
    repeat (10) step();
    chk("t5 one load L2", 32'(pcw_cnt[0] - base0), 32'd1);
    chk("t5 one load L1", 32'(pcw_cnt[1] - base1), 32'd1);
    chk("t5 pc_out", pc_out[0], 32'h12);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
